qam_symbol_scheduler: RTL and testbench
=======================================

# qam_symbol_scheduler

Sequences the 16-QAM modulator: accepts payload bytes over a valid/ready handshake, splits each byte into two 4-bit symbol indices, and presents each index to the modulator's symbol-select input for exactly SAMPLES_PER_SYMBOL clocks. Each frame is wrapped with a fixed preamble and a silent guard interval. Sits between the framing/byte source and the QAM modulator, driving the modulator's block and block-valid inputs directly.

## Interface
- SAMPLES_PER_SYMBOL, 8: clocks per symbol; legal values 1..256.
- PREAMBLE_LEN, 16: preamble symbols per frame; legal values 1..255.
- GUARD_LEN, 4: silent symbol slots after each frame; legal values 1..255.
- ipClk  in  1  system clock, rising edge.
- ipReset  in  1  asynchronous, active-low reset.
- ipData  in  8  payload byte.
- ipDataValid  in  1  ipData is valid.
- ipDataLast  in  1  byte is the last of its frame; qualified by ipDataValid.
- opDataReady  out  1  byte buffer can accept a byte.
- opQAMBlock  out  4  symbol index to the modulator.
- opQAMBlockValid  out  1  opQAMBlock is valid this cycle.
- opSymbolStrobe  out  1  one-cycle pulse on the first cycle of each emitted symbol.
- opBusy  out  1  high in any state other than IDLE.
- opUnderrun  out  1  one-cycle pulse when a payload symbol slot finds no data.

## Operation
- A byte is transferred on a rising edge with ipDataValid && opDataReady. It goes into a one-entry buffer together with its last flag.
- opDataReady = ipReset && !bufFull. This is the only combinational output.
- Payload nibble order per byte: ipData[3:0] first, then ipData[7:4].
- The buffer is freed when its byte is loaded into the shift register at the start of that byte's low-nibble symbol.
- A symbol counter runs 0..SAMPLES_PER_SYMBOL-1. A symbol boundary occurs when the counter wraps.
- FSM states:
  - IDLE: outputs quiet. When bufFull is set, go to PREAMBLE.
  - PREAMBLE: emit PREAMBLE_LEN symbols alternating 4'b0000, 4'b1111, starting with 4'b0000. After the last one, go to PAYLOAD.
  - PAYLOAD:
    - Low-nibble slot with the buffer full: load the shift register, emit [3:0].
    - Low-nibble slot with the buffer empty: underrun. Pulse opUnderrun, deassert opQAMBlockValid, hold the counter at 0, and retry every cycle until the buffer fills. The first symbol after an underrun starts a fresh full-length symbol.
    - High-nibble slot: always emit [7:4] from the shift register; this slot never underruns.
    - After the high nibble of a last-flagged byte completes, go to GUARD.
  - GUARD: opQAMBlockValid = 0 and opQAMBlock = 0 for GUARD_LEN symbol times, then go to IDLE.
- During PREAMBLE the buffer may fill. The first payload byte waits in the buffer, and opDataReady stays low until it is loaded.
- Bytes arriving during GUARD are buffered. They start the next frame only after GUARD finishes.

## Timing
- Reset: while ipReset is low, all registered outputs are 0, the FSM is in IDLE, the buffer is empty, and opDataReady is 0.
- A byte accepted at edge t makes bufFull = 1 after edge t. IDLE leaves at edge t+1. The first preamble symbol has opQAMBlockValid = 1 and opSymbolStrobe = 1 in the cycle after edge t+1.
- Every emitted symbol holds opQAMBlock stable with opQAMBlockValid = 1 for exactly SAMPLES_PER_SYMBOL consecutive cycles.
- With SAMPLES_PER_SYMBOL = 1, opSymbolStrobe is high on every valid cycle.
- Symbols within PREAMBLE and PAYLOAD are back-to-back with no bubble, unless an underrun occurs.
- A byte accepted on the same edge as the buffer-to-shift-register load is legal. Free and fill resolve the buffer to full.
- Asserting reset mid-frame aborts the frame immediately. No guard interval is emitted and buffered data is discarded.

## Configuration
- QAM_SCHED_PREAMBLE_EN defined: PREAMBLE state and the PREAMBLE_LEN behaviour as above.
- QAM_SCHED_PREAMBLE_EN undefined: PREAMBLE state is removed and IDLE goes directly to PAYLOAD. The first payload symbol appears in the cycle after edge t+1. PREAMBLE_LEN is ignored.

## Test plan
- Single frame, SPS=8, PREAMBLE_LEN=16, GUARD_LEN=4, bytes 0xA5 and 0x3C (last) -> 16 alternating 0/F preamble symbols of 8 cycles each; then payload 5, A, C, 3 of 8 cycles each; then 32 cycles with valid = 0; then opBusy falls.
- Continuous source with valid held high, 6-byte frame -> 12 contiguous payload symbols, no opUnderrun, opDataReady low except right after each load.
- Source gap: byte 2 arrives 20 cycles late -> one opUnderrun pulse after the high nibble of byte 1, valid = 0 during the gap, and byte 2's low nibble runs a full 8 cycles from its start.
- SPS=1, macro undefined, byte 0x12 (last) -> first cycle after edge t+1 shows 2, next cycle 1, strobe on both, then 4 invalid cycles.
- Reset asserted in cycle 5 of a payload symbol -> all outputs 0 immediately; after release, opDataReady = 1 and the next frame starts with a fresh preamble.
- Two back-to-back frames (second frame's first byte offered during GUARD) -> second preamble starts exactly GUARD_LEN×SPS cycles after the last payload symbol ends.

Source files
------------

// File: rtl/qam_symbol_scheduler_if.sv
// Byte-source handshake and modulator-facing signals of qam_symbol_scheduler.
// master: byte source / modulator side; slave: the scheduler.
interface qam_symbol_scheduler_if;
  logic [7:0] ipData;
  logic       ipDataValid;
  logic       ipDataLast;
  logic       opDataReady;
  logic [3:0] opQAMBlock;
  logic       opQAMBlockValid;
  logic       opSymbolStrobe;
  logic       opBusy;
  logic       opUnderrun;

  modport master (
    output ipData, ipDataValid, ipDataLast,
    input  opDataReady, opQAMBlock, opQAMBlockValid, opSymbolStrobe, opBusy, opUnderrun
  );

  modport slave (
    input  ipData, ipDataValid, ipDataLast,
    output opDataReady, opQAMBlock, opQAMBlockValid, opSymbolStrobe, opBusy, opUnderrun
  );
endinterface

// File: rtl/qam_symbol_scheduler.sv
// 16-QAM symbol scheduler: buffers payload bytes, emits preamble, low/high
// payload nibbles and a silent guard, each symbol held SAMPLES_PER_SYMBOL clocks.
// Optional feature: define QAM_SCHED_PREAMBLE_EN to emit the alternating 0/F
// preamble; without it IDLE goes straight to PAYLOAD and PREAMBLE_LEN only
// sizes the slot counter.
module qam_symbol_scheduler #(
  parameter int unsigned SAMPLES_PER_SYMBOL = 8,
  parameter int unsigned PREAMBLE_LEN       = 16,
  parameter int unsigned GUARD_LEN          = 4
) (
  input logic                   ipClk,
  input logic                   ipReset,
  qam_symbol_scheduler_if.slave bus
);

  localparam int unsigned CW      = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int unsigned IDX_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int unsigned IW      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] GUARD_LAST = IW'(GUARD_LEN - 1);
`ifdef QAM_SCHED_PREAMBLE_EN
  localparam logic [IW-1:0] PRE_LAST   = IW'(PREAMBLE_LEN - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
`ifdef QAM_SCHED_PREAMBLE_EN
    PREAMBLE,
`endif
    PAYLOAD,
    GUARD
  } stateT;

  stateT         state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] symIdx;
  logic          bufFull;
  logic [7:0]    bufData;
  logic          bufLast;
  logic [3:0]    shHigh;
  logic          shLast;
  logic          nibHigh;
  logic [3:0]    qamBlock;
  logic          qamValid;
  logic          symStrobe;
  logic          busy;
  logic          underrun;

  logic dataReady;
  logic accept;
  logic symEnd;
  logic startPre;
  logic lowSlot;
  logic highSlot;
  logic enterGuard;

  assign dataReady = ipReset & ~bufFull;
  assign accept    = bus.ipDataValid & dataReady;
  assign symEnd    = (cnt == CNT_LAST);

  // Decide which kind of symbol slot (if any) begins at the coming edge.
  always_comb begin
    startPre   = 1'b0;
    lowSlot    = 1'b0;
    highSlot   = 1'b0;
    enterGuard = 1'b0;
    case (state)
      IDLE: begin
        if (bufFull) begin
`ifdef QAM_SCHED_PREAMBLE_EN
          startPre = 1'b1;
`else
          lowSlot = 1'b1;
`endif
        end
      end
`ifdef QAM_SCHED_PREAMBLE_EN
      PREAMBLE: lowSlot = symEnd && (symIdx == PRE_LAST);
`endif
      PAYLOAD: begin
        // Invalid output in PAYLOAD means an underrun wait: retry every cycle.
        if (!qamValid) begin
          lowSlot = 1'b1;
        end else if (symEnd) begin
          if (!nibHigh)    highSlot   = 1'b1;
          else if (shLast) enterGuard = 1'b1;
          else             lowSlot    = 1'b1;
        end
      end
      GUARD: begin
        // A byte buffered during the guard starts the next frame with no idle gap.
        if (symEnd && (symIdx == GUARD_LAST) && bufFull) begin
`ifdef QAM_SCHED_PREAMBLE_EN
          startPre = 1'b1;
`else
          lowSlot = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Frame sequencer: byte buffer, symbol timing and registered modulator outputs.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state     <= IDLE;
      cnt       <= '0;
      symIdx    <= '0;
      bufFull   <= 1'b0;
      bufData   <= '0;
      bufLast   <= 1'b0;
      shHigh    <= '0;
      shLast    <= 1'b0;
      nibHigh   <= 1'b0;
      qamBlock  <= '0;
      qamValid  <= 1'b0;
      symStrobe <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      symStrobe <= 1'b0;
      underrun  <= 1'b0;

      if (accept) begin
        bufData <= bus.ipData;
        bufLast <= bus.ipDataLast;
        bufFull <= 1'b1;
      end else if (lowSlot) begin
        bufFull <= 1'b0;
      end

      case (state)
`ifdef QAM_SCHED_PREAMBLE_EN
        PREAMBLE: begin
          if (symEnd) begin
            cnt       <= '0;
            symIdx    <= symIdx + IDX_ONE;
            qamBlock  <= {4{~symIdx[0]}};
            symStrobe <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        PAYLOAD: begin
          if (qamValid) begin
            if (symEnd) begin
              cnt <= '0;
              if (highSlot) begin
                qamBlock  <= shHigh;
                nibHigh   <= 1'b1;
                symStrobe <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        GUARD: begin
          if (symEnd) begin
            cnt    <= '0;
            symIdx <= symIdx + IDX_ONE;
            if (symIdx == GUARD_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase

      // Slot events below override the per-state bookkeeping above.
      if (enterGuard) begin
        state    <= GUARD;
        busy     <= 1'b1;
        qamValid <= 1'b0;
        qamBlock <= '0;
        symIdx   <= '0;
        cnt      <= '0;
      end

`ifdef QAM_SCHED_PREAMBLE_EN
      if (startPre) begin
        state     <= PREAMBLE;
        busy      <= 1'b1;
        qamValid  <= 1'b1;
        qamBlock  <= 4'h0;
        symStrobe <= 1'b1;
        symIdx    <= '0;
        cnt       <= '0;
      end
`endif

      if (lowSlot) begin
        state   <= PAYLOAD;
        busy    <= 1'b1;
        cnt     <= '0;
        nibHigh <= 1'b0;
        if (bufFull) begin
          shHigh    <= bufData[7:4];
          shLast    <= bufLast;
          qamBlock  <= bufData[3:0];
          qamValid  <= 1'b1;
          symStrobe <= 1'b1;
        end else begin
          // Pulse only on the first miss; later retries stay silent.
          underrun <= qamValid;
          qamValid <= 1'b0;
          qamBlock <= '0;
        end
      end
    end
  end

  assign bus.opDataReady     = dataReady;
  assign bus.opQAMBlock      = qamBlock;
  assign bus.opQAMBlockValid = qamValid;
  assign bus.opSymbolStrobe  = symStrobe;
  assign bus.opBusy          = busy;
  assign bus.opUnderrun      = underrun;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Testbench for qam_symbol_scheduler: directed and randomized byte streams,
// every output sample compared against a timing model built from frame rules.
module tb_qam_symbol_scheduler;
  localparam int unsigned SPS_A = 8;
  localparam int unsigned PRE_A = 16;
  localparam int unsigned GL_A  = 4;
  localparam int unsigned SPS_B = 1;
  localparam int unsigned PRE_B = 3;
  localparam int unsigned GL_B  = 4;
`ifdef QAM_SCHED_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif
  localparam int unsigned PRE_SYM_A = PRE_EN ? PRE_A : 0;
  localparam int unsigned PRE_SYM_B = PRE_EN ? PRE_B : 0;

  typedef struct packed {
    logic       v;
    logic [3:0] blk;
    logic       stb;
    logic       und;
    logic       busy;
    logic       rdy;
  } obsT;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int unsigned passCnt = 0;
  int unsigned failCnt = 0;
  int unsigned totalCnt = 0;

  obsT         trace[$];
  obsT         expTr[$];
  int unsigned acc[$];
  logic [7:0]  srcData[$];
  bit          srcLast[$];
  int unsigned srcGap[$];

  always #5 clk = ~clk;

  qam_symbol_scheduler_if busA();
  qam_symbol_scheduler_if busB();

  qam_symbol_scheduler #(.SAMPLES_PER_SYMBOL(SPS_A), .PREAMBLE_LEN(PRE_A), .GUARD_LEN(GL_A))
    dutA (.ipClk(clk), .ipReset(rstN), .bus(busA));
  qam_symbol_scheduler #(.SAMPLES_PER_SYMBOL(SPS_B), .PREAMBLE_LEN(PRE_B), .GUARD_LEN(GL_B))
    dutB (.ipClk(clk), .ipReset(rstN), .bus(busB));

  task automatic check(input string tag, input int unsigned obs, input int unsigned req);
    totalCnt++;
    assert (obs === req) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  function automatic obsT getObs(input bit sel);
    obsT o;
    if (sel) o = {busB.opQAMBlockValid, busB.opQAMBlock, busB.opSymbolStrobe,
                  busB.opUnderrun, busB.opBusy, busB.opDataReady};
    else     o = {busA.opQAMBlockValid, busA.opQAMBlock, busA.opSymbolStrobe,
                  busA.opUnderrun, busA.opBusy, busA.opDataReady};
    return o;
  endfunction

  task automatic setIn(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      busB.ipDataValid = v; busB.ipData = d; busB.ipDataLast = l;
    end else begin
      busA.ipDataValid = v; busA.ipData = d; busA.ipDataLast = l;
    end
  endtask

  function automatic int unsigned maxu(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Drive the queued bytes (gap = idle cycles before offering each byte),
  // record one sample per cycle until the DUT has gone idle.
  task automatic runStream(input bit sel, input string tag);
    int unsigned k = 0;
    int unsigned gap;
    int unsigned idleRun = 0;
    bit done = 1'b0;
    obsT o;
    trace.delete();
    acc.delete();
    gap = srcGap[0];
    for (int unsigned c = 0; c < 5000 && !done; c++) begin
      if (k < srcData.size() && gap == 0) setIn(sel, 1'b1, srcData[k], srcLast[k]);
      else setIn(sel, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      o = getObs(sel);
      trace.push_back(o);
      if (k < srcData.size() && gap == 0) begin
        if (o.rdy) begin
          acc.push_back(c);
          k++;
          gap = (k < srcData.size()) ? srcGap[k] : 0;
        end
      end else if (gap > 0) begin
        gap--;
      end
      idleRun = (k == srcData.size() && !o.busy) ? idleRun + 1 : 0;
      done = (idleRun >= 3);
      @(posedge clk); #1;
    end
    setIn(sel, 1'b0, 8'h00, 1'b0);
    check({tag, "/completed"}, done, 1);
    check({tag, "/bytesAccepted"}, acc.size(), srcData.size());
  endtask

  function automatic void putSym(input int unsigned s, input int unsigned len, input logic [3:0] val);
    obsT e;
    for (int unsigned i = 0; i < len; i++) begin
      if (s + i < expTr.size()) begin
        e = expTr[s + i]; e.v = 1'b1; e.blk = val; e.stb = (i == 0); expTr[s + i] = e;
      end
    end
  endfunction

  // Expected trace from frame rules: a byte is usable two samples after its
  // accept sample; each frame = preamble, two nibbles per byte, guard.
  function automatic void buildExpected(input int unsigned sps, input int unsigned pre, input int unsigned gl);
    int unsigned t = 0;
    int unsigned k = 0;
    int unsigned s, st, fs;
    bit lastB;
    obsT e;
    expTr.delete();
    foreach (trace[i]) begin
      e = '0; e.rdy = 1'b1; expTr.push_back(e);
    end
    while (k < acc.size()) begin
      fs = maxu(t, acc[k] + 2);
      s = fs;
      for (int unsigned p = 0; p < pre; p++) begin
        putSym(s, sps, (p % 2 == 1) ? 4'hF : 4'h0);
        s += sps;
      end
      do begin
        st = maxu(s, acc[k] + 2);
        if (st > s && s < expTr.size()) begin
          e = expTr[s]; e.und = 1'b1; expTr[s] = e;
        end
        for (int unsigned j = acc[k] + 1; j < st && j < expTr.size(); j++) begin
          e = expTr[j]; e.rdy = 1'b0; expTr[j] = e;
        end
        putSym(st, sps, srcData[k][3:0]);
        putSym(st + sps, sps, srcData[k][7:4]);
        s = st + 2 * sps;
        lastB = srcLast[k];
        k++;
      end while (!lastB && k < acc.size());
      s += gl * sps;
      for (int unsigned j = fs; j < s && j < expTr.size(); j++) begin
        e = expTr[j]; e.busy = 1'b1; expTr[j] = e;
      end
      t = s;
    end
  endfunction

  task automatic compareTrace(input string tag);
    int unsigned bad[6];
    int unsigned first[6];
    string names[6];
    obsT o, x;
    names = '{"valid", "block", "strobe", "underrun", "busy", "ready"};
    for (int i = 0; i < 6; i++) begin bad[i] = 0; first[i] = 0; end
    foreach (trace[i]) begin
      o = trace[i];
      x = expTr[i];
      if (o.v !== x.v)                              begin if (bad[0] == 0) first[0] = i; bad[0]++; end
      if ((x.v || !x.busy) && (o.blk !== x.blk))    begin if (bad[1] == 0) first[1] = i; bad[1]++; end
      if (o.stb !== x.stb)                          begin if (bad[2] == 0) first[2] = i; bad[2]++; end
      if (o.und !== x.und)                          begin if (bad[3] == 0) first[3] = i; bad[3]++; end
      if (o.busy !== x.busy)                        begin if (bad[4] == 0) first[4] = i; bad[4]++; end
      if (o.rdy !== x.rdy)                          begin if (bad[5] == 0) first[5] = i; bad[5]++; end
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("%s/%s badSamples(first@%0d)", tag, names[i], first[i]), bad[i], 0);
  endtask

  // kind 0: valid samples, 1: underrun pulses, 2: busy but silent samples
  function automatic int unsigned countObs(input int kind);
    int unsigned n = 0;
    foreach (trace[i]) begin
      case (kind)
        0: if (trace[i].v) n++;
        1: if (trace[i].und) n++;
        default: if (trace[i].busy && !trace[i].v) n++;
      endcase
    end
    return n;
  endfunction

  task automatic makeFrames(input int unsigned nFrames, input int unsigned maxGap);
    int unsigned len;
    srcData.delete(); srcLast.delete(); srcGap.delete();
    for (int unsigned f = 0; f < nFrames; f++) begin
      len = $urandom_range(4, 1);
      for (int unsigned b = 0; b < len; b++) begin
        srcData.push_back(8'($urandom_range(255, 0)));
        srcLast.push_back(b == len - 1);
        srcGap.push_back(($urandom_range(2, 0) == 0) ? $urandom_range(maxGap, 0) : 0);
      end
    end
  endtask

  initial begin
    int unsigned j, g0, off;
    obsT o;
    setIn(1'b0, 1'b0, 8'h00, 1'b0);
    setIn(1'b1, 1'b0, 8'h00, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset/outputsA", getObs(1'b0), 0);
    check("reset/outputsB", getObs(1'b1), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check("reset/readyAfterRelease", busA.opDataReady, 1);
    @(posedge clk); #1;

    // Single frame A5, 3C
    srcData = '{8'hA5, 8'h3C}; srcLast = '{1'b0, 1'b1}; srcGap = '{0, 0};
    runStream(1'b0, "single");
    buildExpected(SPS_A, PRE_SYM_A, GL_A);
    compareTrace("single");
    check("single/validSamples", countObs(0), (PRE_SYM_A + 4) * SPS_A);
    check("single/guardSamples", countObs(2), GL_A * SPS_A);

    // Continuous source, 6-byte frame
    srcData.delete(); srcLast.delete(); srcGap.delete();
    for (int i = 0; i < 6; i++) begin
      srcData.push_back(8'($urandom_range(255, 0))); srcLast.push_back(i == 5); srcGap.push_back(0);
    end
    runStream(1'b0, "continuous");
    buildExpected(SPS_A, PRE_SYM_A, GL_A);
    compareTrace("continuous");
    check("continuous/underruns", countObs(1), 0);

    // Late second byte -> one underrun
    srcData = '{8'h96, 8'h4E}; srcLast = '{1'b0, 1'b1}; srcGap = '{0, PRE_SYM_A * SPS_A + 20};
    runStream(1'b0, "gap");
    buildExpected(SPS_A, PRE_SYM_A, GL_A);
    compareTrace("gap");
    check("gap/underruns", countObs(1), 1);

    // Back-to-back frames: second frame waits in the buffer through the guard
    srcData = '{8'h11, 8'h22, 8'h33, 8'h44}; srcLast = '{1'b0, 1'b1, 1'b0, 1'b1};
    srcGap = '{0, 0, 0, 0};
    runStream(1'b0, "b2b");
    buildExpected(SPS_A, PRE_SYM_A, GL_A);
    compareTrace("b2b");
    j = 0;
    while (j < trace.size() && !trace[j].v) j++;
    while (j < trace.size() && trace[j].v) j++;
    g0 = j;
    while (j < trace.size() && !trace[j].v) j++;
    check("b2b/guardGap", j - g0, GL_A * SPS_A);

    // Randomized multi-frame streams on both instances
    makeFrames(3, 30);
    runStream(1'b0, "randA");
    buildExpected(SPS_A, PRE_SYM_A, GL_A);
    compareTrace("randA");

    // SPS = 1 boundary
    srcData = '{8'h12}; srcLast = '{1'b1}; srcGap = '{0};
    runStream(1'b1, "sps1");
    buildExpected(SPS_B, PRE_SYM_B, GL_B);
    compareTrace("sps1");
    off = acc[0] + 2 + PRE_SYM_B;
    o = trace[off];
    check("sps1/firstNibble", {o.v, o.blk, o.stb}, {1'b1, 4'h2, 1'b1});
    o = trace[off + 1];
    check("sps1/secondNibble", {o.v, o.blk, o.stb}, {1'b1, 4'h1, 1'b1});
    check("sps1/guardSamples", countObs(2), GL_B);

    makeFrames(3, 6);
    runStream(1'b1, "randB");
    buildExpected(SPS_B, PRE_SYM_B, GL_B);
    compareTrace("randB");

    // Reset in cycle 5 of a payload symbol
    setIn(1'b0, 1'b1, 8'h5A, 1'b1);
    @(negedge clk);
    check("midReset/readyIdle", busA.opDataReady, 1);
    @(posedge clk); #1;
    setIn(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2 + PRE_SYM_A * SPS_A + 4) @(negedge clk);
    o = getObs(1'b0);
    check("midReset/lowNibbleBefore", {o.v, o.blk}, {1'b1, 4'hA});
    #2 rstN = 1'b0;
    #1;
    check("midReset/outputsCleared", getObs(1'b0), 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    o = '0; o.rdy = 1'b1;
    check("midReset/afterRelease", getObs(1'b0), o);
    @(posedge clk); #1;
    srcData = '{8'hC3}; srcLast = '{1'b1}; srcGap = '{0};
    runStream(1'b0, "postReset");
    buildExpected(SPS_A, PRE_SYM_A, GL_A);
    compareTrace("postReset");

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
